// File: rtl/panel_switch_ctrl_pkg.sv
// Shared types and PS/2 scancodes for the keyboard-driven front-panel switch controller.
// The digit lookup is only used when PANEL_DIRECT_KEYS_EN is defined.
package panel_pkg;

  typedef enum logic [1:0] {
    SW_CENTER = 2'b00,
    SW_UP     = 2'b01,
    SW_DOWN   = 2'b10
  } sw_pos_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    WAIT = 2'd2
  } mom_state_t;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;

  // One-cycle command strobes produced by the key decoder.
  typedef struct packed {
    logic       left;
    logic       right;
    logic       up_p;
    logic       down_p;
    logic       up_r;
    logic       down_r;
    logic       digit_v;
    logic [2:0] digit_idx;
  } key_cmd_t;

  // Returns {valid, index} for the top-row digit keys '1'..'8'.
  function automatic logic [3:0] digit_decode(input logic [7:0] sc);
    case (sc)
      SC_D1:   return {1'b1, 3'd0};
      SC_D2:   return {1'b1, 3'd1};
      SC_D3:   return {1'b1, 3'd2};
      SC_D4:   return {1'b1, 3'd3};
      SC_D5:   return {1'b1, 3'd4};
      SC_D6:   return {1'b1, 3'd5};
      SC_D7:   return {1'b1, 3'd6};
      SC_D8:   return {1'b1, 3'd7};
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/panel_switch_ctrl_key_decode.sv
// Turns hps_io ps2_key events into one-hot command strobes; owns the event-toggle copy kbit_q.
// Direct digit cursor keys are decoded only when PANEL_DIRECT_KEYS_EN is defined.
module panel_key_decode
  import panel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output key_cmd_t    cmd_c
);

  logic       kbit_q;
  logic       kbit_d;
  logic       key_ev_c;
  logic       ext_press_c;
  logic       ext_rel_c;
  logic [7:0] code_c;

  always_comb begin
    kbit_d = ps2_key[10];
  end

  // Reset also tracks the live toggle bit so leaving reset never looks like a key event.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbit_q <= ps2_key[10];
    end else begin
      kbit_q <= kbit_d;
    end
  end

  always_comb begin
    cmd_c       = '0;
    code_c      = ps2_key[7:0];
    key_ev_c    = (ps2_key[10] != kbit_q);
    ext_press_c = key_ev_c & ps2_key[8] & ps2_key[9];
    ext_rel_c   = key_ev_c & ps2_key[8] & ~ps2_key[9];

    cmd_c.right  = ext_press_c && (code_c == SC_RIGHT);
    cmd_c.left   = ext_press_c && (code_c == SC_LEFT);
    cmd_c.up_p   = ext_press_c && (code_c == SC_UP);
    cmd_c.down_p = ext_press_c && (code_c == SC_DOWN);
    cmd_c.up_r   = ext_rel_c && (code_c == SC_UP);
    cmd_c.down_r = ext_rel_c && (code_c == SC_DOWN);

`ifdef PANEL_DIRECT_KEYS_EN
    if (key_ev_c && !ps2_key[8] && ps2_key[9]) begin
      {cmd_c.digit_v, cmd_c.digit_idx} = digit_decode(code_c);
    end
`else
    cmd_c.digit_v   = 1'b0;
    cmd_c.digit_idx = 3'd0;
`endif
  end

endmodule

// File: rtl/panel_switch_ctrl.sv
// Keyboard-driven front-panel switch array: cursor, 3-position toggle/momentary switches and a
// one-entry state-change event port. Optional direct cursor keys: PANEL_DIRECT_KEYS_EN.
module panel_switch_ctrl
  import panel_pkg::*;
#(
  parameter int unsigned SWITCH_COUNT   = 25,
  parameter logic [63:0] MOMENTARY_MASK = 64'h0,
  parameter logic [23:0] HOLD_CYCLES    = 24'd2_000_000,
  parameter int unsigned IDX_W          = $clog2(SWITCH_COUNT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [10:0]               ps2_key,
  output logic [2*SWITCH_COUNT-1:0] sw_state,
  output logic [IDX_W-1:0]          cursor,
  output logic                      ev_valid,
  output logic [IDX_W-1:0]          ev_index,
  output logic [1:0]                ev_state,
  input  logic                      ev_ready,
  output logic                      ev_overrun
);

  localparam int unsigned     SW_W      = 2 * SWITCH_COUNT;
  localparam logic [23:0]     HOLD_LOAD = (HOLD_CYCLES == 24'd0) ? 24'd0 : HOLD_CYCLES - 24'd1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SWITCH_COUNT - 1);

  key_cmd_t cmd_c;

  logic [SW_W-1:0]  sw_state_q,   sw_state_d;
  logic [IDX_W-1:0] cursor_q,     cursor_d;
  mom_state_t       mom_q,        mom_d;
  logic [23:0]      hold_cnt_q,   hold_cnt_d;
  logic [IDX_W-1:0] held_idx_q,   held_idx_d;
  sw_pos_t          held_key_q,   held_key_d;
  logic             ev_valid_q,   ev_valid_d;
  logic [IDX_W-1:0] ev_index_q,   ev_index_d;
  logic [1:0]       ev_state_q,   ev_state_d;
  logic             ev_overrun_q, ev_overrun_d;

  sw_pos_t          cur_pos_c;
  logic             cur_mom_c;
  logic             press_c;
  sw_pos_t          press_pos_c;
  logic             held_rel_c;
  logic             chg_c;
  logic [IDX_W-1:0] chg_idx_c;
  sw_pos_t          chg_pos_c;

  panel_key_decode u_key_decode (
    .clk     (clk),
    .reset   (reset),
    .ps2_key (ps2_key),
    .cmd_c   (cmd_c)
  );

  assign cur_pos_c = sw_pos_t'(2'(sw_state_q >> {cursor_q, 1'b0}));
  assign cur_mom_c = 1'(MOMENTARY_MASK >> cursor_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_state_q   <= '0;
      cursor_q     <= '0;
      mom_q        <= IDLE;
      hold_cnt_q   <= '0;
      held_idx_q   <= '0;
      held_key_q   <= SW_CENTER;
      ev_valid_q   <= 1'b0;
      ev_index_q   <= '0;
      ev_state_q   <= 2'b00;
      ev_overrun_q <= 1'b0;
    end else begin
      sw_state_q   <= sw_state_d;
      cursor_q     <= cursor_d;
      mom_q        <= mom_d;
      hold_cnt_q   <= hold_cnt_d;
      held_idx_q   <= held_idx_d;
      held_key_q   <= held_key_d;
      ev_valid_q   <= ev_valid_d;
      ev_index_q   <= ev_index_d;
      ev_state_q   <= ev_state_d;
      ev_overrun_q <= ev_overrun_d;
    end
  end

  always_comb begin
    cursor_d     = cursor_q;
    mom_d        = mom_q;
    hold_cnt_d   = hold_cnt_q;
    held_idx_d   = held_idx_q;
    held_key_d   = held_key_q;
    ev_valid_d   = ev_valid_q;
    ev_index_d   = ev_index_q;
    ev_state_d   = ev_state_q;
    ev_overrun_d = ev_overrun_q;
    sw_state_d   = sw_state_q;
    chg_c        = 1'b0;
    chg_idx_c    = cursor_q;
    chg_pos_c    = SW_CENTER;
    press_c      = cmd_c.up_p | cmd_c.down_p;
    press_pos_c  = cmd_c.up_p ? SW_UP : SW_DOWN;
    held_rel_c   = ((held_key_q == SW_UP) && cmd_c.up_r) ||
                   ((held_key_q == SW_DOWN) && cmd_c.down_r);

    // Cursor navigation is honoured in every momentary state.
    if (cmd_c.right) begin
      cursor_d = (cursor_q == LAST_IDX) ? '0 : cursor_q + IDX_W'(1);
    end else if (cmd_c.left) begin
      cursor_d = (cursor_q == '0) ? LAST_IDX : cursor_q - IDX_W'(1);
    end else if (cmd_c.digit_v && (32'(cmd_c.digit_idx) < SWITCH_COUNT)) begin
      cursor_d = IDX_W'(cmd_c.digit_idx);
    end

    if ((mom_q != IDLE) && (hold_cnt_q != 24'd0)) begin
      hold_cnt_d = hold_cnt_q - 24'd1;
    end

    case (mom_q)
      IDLE: begin
        if (press_c) begin
          if (cur_mom_c) begin
            chg_c      = 1'b1;
            chg_pos_c  = press_pos_c;
            mom_d      = HELD;
            hold_cnt_d = HOLD_LOAD;
            held_idx_d = cursor_q;
            held_key_d = press_pos_c;
          end else if (cur_pos_c != press_pos_c) begin
            chg_c     = 1'b1;
            chg_pos_c = press_pos_c;
          end
        end
      end
      HELD: begin
        if (held_rel_c) begin
          mom_d = WAIT;
        end
      end
      WAIT: begin
        if (hold_cnt_q == 24'd0) begin
          chg_c     = 1'b1;
          chg_idx_c = held_idx_q;
          chg_pos_c = SW_CENTER;
          mom_d     = IDLE;
        end
      end
      default: begin
        mom_d = IDLE;
      end
    endcase

    if (chg_c) begin
      sw_state_d = (sw_state_q & ~(SW_W'(2'b11) << {chg_idx_c, 1'b0})) |
                   (SW_W'(chg_pos_c) << {chg_idx_c, 1'b0});
    end

    // Single-entry event slot: accept clears, a new change overwrites; overrun only if it was unread.
    if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
    if (chg_c) begin
      ev_valid_d = 1'b1;
      ev_index_d = chg_idx_c;
      ev_state_d = chg_pos_c;
      if (ev_valid_q && !ev_ready) begin
        ev_overrun_d = 1'b1;
      end
    end
  end

  assign sw_state   = sw_state_q;
  assign cursor     = cursor_q;
  assign ev_valid   = ev_valid_q;
  assign ev_index   = ev_index_q;
  assign ev_state   = ev_state_q;
  assign ev_overrun = ev_overrun_q;

endmodule

// File: tb/tb_panel_switch_ctrl.sv
// Directed bench for panel_switch_ctrl (4 switches, switch 0 momentary, 10-cycle hold) with an
// event scoreboard that checks every accepted event in order.
module tb_panel_switch_ctrl;

  localparam int unsigned SC = 4;
  localparam int unsigned IW = 2;
  localparam logic [7:0]  K_R = 8'h74;
  localparam logic [7:0]  K_L = 8'h6B;
  localparam logic [7:0]  K_U = 8'h75;
  localparam logic [7:0]  K_D = 8'h72;

  logic            clk = 1'b0;
  logic            reset;
  logic [10:0]     ps2_key;
  logic            ev_ready;
  logic [2*SC-1:0] sw_state;
  logic [IW-1:0]   cursor;
  logic            ev_valid;
  logic [IW-1:0]   ev_index;
  logic [1:0]      ev_state;
  logic            ev_overrun;

  int errors = 0;
  int checks = 0;
  int deflect;
  logic [3:0] exp_q[$];

  panel_switch_ctrl #(
    .SWITCH_COUNT   (SC),
    .MOMENTARY_MASK (64'h1),
    .HOLD_CYCLES    (24'd10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .sw_state   (sw_state),
    .cursor     (cursor),
    .ev_valid   (ev_valid),
    .ev_index   (ev_index),
    .ev_state   (ev_state),
    .ev_ready   (ev_ready),
    .ev_overrun (ev_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one key event at a negedge; returns at the negedge after the DUT sampled it.
  task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ev_ready = v;
    @(negedge clk);
  endtask

  // Scoreboard: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 64'({ev_index, ev_state}), 64'hFF);
      end else begin
        chk("event", 64'({ev_index, ev_state}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    ps2_key  = '0;
    ev_ready = 1'b1;
    tick(2);
    chk("rst_sw", 64'(sw_state), 64'h0);
    chk("rst_cursor", 64'(cursor), 64'h0);
    chk("rst_valid", 64'(ev_valid), 64'h0);
    chk("rst_index", 64'(ev_index), 64'h0);
    chk("rst_state", 64'(ev_state), 64'h0);
    chk("rst_overrun", 64'(ev_overrun), 64'h0);
    reset = 1'b0;
    tick(1);

    // Cursor navigation
    key(1'b1, 1'b1, K_R); chk("cur_1", 64'(cursor), 64'h1);
    key(1'b0, 1'b1, K_R); chk("cur_rel", 64'(cursor), 64'h1);
    key(1'b1, 1'b1, K_R); chk("cur_2", 64'(cursor), 64'h2);
    key(1'b1, 1'b1, K_R); chk("cur_3", 64'(cursor), 64'h3);
    key(1'b1, 1'b1, K_L); chk("cur_back2", 64'(cursor), 64'h2);
    key(1'b1, 1'b0, K_R); chk("cur_nonext", 64'(cursor), 64'h2);
    chk("nav_sw", 64'(sw_state), 64'h0);
    chk("nav_valid", 64'(ev_valid), 64'h0);

    // Toggle switch 2
    exp_q.push_back({2'd2, 2'b01});
    key(1'b1, 1'b1, K_U);
    chk("tog_sw", 64'(sw_state), 64'h10);
    chk("tog_valid", 64'(ev_valid), 64'h1);
    chk("tog_index", 64'(ev_index), 64'h2);
    chk("tog_state", 64'(ev_state), 64'h1);
    key(1'b0, 1'b1, K_U);
    chk("tog_accept", 64'(ev_valid), 64'h0);
    key(1'b1, 1'b1, K_U);
    chk("tog_repeat_sw", 64'(sw_state), 64'h10);
    chk("tog_repeat_valid", 64'(ev_valid), 64'h0);
    key(1'b1, 1'b0, K_U);
    chk("tog_nonext", 64'(sw_state), 64'h10);

    // Wrap at both ends
    key(1'b1, 1'b1, K_R); chk("wrap_3", 64'(cursor), 64'h3);
    key(1'b1, 1'b1, K_R); chk("wrap_to0", 64'(cursor), 64'h0);
    key(1'b1, 1'b1, K_L); chk("wrap_to3", 64'(cursor), 64'h3);
    key(1'b1, 1'b1, K_R); chk("wrap_back0", 64'(cursor), 64'h0);

    // Momentary switch 0, early release: deflected exactly HOLD_CYCLES
    exp_q.push_back({2'd0, 2'b01});
    exp_q.push_back({2'd0, 2'b00});
    deflect = 0;
    key(1'b1, 1'b1, K_U);
    if (sw_state[1:0] == 2'b01) deflect++;
    repeat (2) begin
      tick(1);
      if (sw_state[1:0] == 2'b01) deflect++;
    end
    key(1'b0, 1'b1, K_U);
    if (sw_state[1:0] == 2'b01) deflect++;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (sw_state[1:0] == 2'b01) deflect++;
    end
    chk("mom_deflect", 64'(deflect), 64'd10);
    chk("mom_center_sw", 64'(sw_state), 64'h10);
    chk("mom_center_state", 64'(ev_state), 64'h0);
    chk("mom_overrun", 64'(ev_overrun), 64'h0);

    // Momentary down, late release; presses and foreign releases ignored while held
    exp_q.push_back({2'd0, 2'b10});
    exp_q.push_back({2'd0, 2'b00});
    key(1'b1, 1'b1, K_D); chk("late_down", 64'(sw_state), 64'h12);
    key(1'b1, 1'b1, K_R); chk("late_cur1", 64'(cursor), 64'h1);
    key(1'b1, 1'b1, K_D); chk("late_ign_press", 64'(sw_state), 64'h12);
    key(1'b0, 1'b1, K_U);
    key(1'b1, 1'b1, K_L); chk("late_cur0", 64'(cursor), 64'h0);
    key(1'b1, 1'b1, K_U); chk("late_ign_held", 64'(sw_state), 64'h12);
    tick(14);
    chk("late_still_held", 64'(sw_state), 64'h12);
    key(1'b0, 1'b1, K_D); chk("late_wait", 64'(sw_state), 64'h12);
    tick(1);
    chk("late_center", 64'(sw_state), 64'h10);

    // Overrun: two changes without ready
    set_ready(1'b0);
    key(1'b1, 1'b1, K_R);
    key(1'b1, 1'b1, K_R);
    key(1'b1, 1'b1, K_D);
    chk("ovr_first_valid", 64'(ev_valid), 64'h1);
    chk("ovr_first_index", 64'(ev_index), 64'h2);
    chk("ovr_first_flag", 64'(ev_overrun), 64'h0);
    key(1'b1, 1'b1, K_R);
    exp_q.push_back({2'd3, 2'b01});
    key(1'b1, 1'b1, K_U);
    chk("ovr_sw", 64'(sw_state), 64'h60);
    chk("ovr_valid", 64'(ev_valid), 64'h1);
    chk("ovr_index", 64'(ev_index), 64'h3);
    chk("ovr_state", 64'(ev_state), 64'h1);
    chk("ovr_flag", 64'(ev_overrun), 64'h1);
    set_ready(1'b1);
    tick(1);
    chk("ovr_cleared", 64'(ev_valid), 64'h0);
    chk("ovr_sticky", 64'(ev_overrun), 64'h1);
    tick(3);
    chk("ovr_sticky_late", 64'(ev_overrun), 64'h1);

    // Reset while HELD: no centering event afterwards
    key(1'b1, 1'b1, K_R); chk("mid_cur0", 64'(cursor), 64'h0);
    exp_q.push_back({2'd0, 2'b01});
    key(1'b1, 1'b1, K_U); chk("mid_held", 64'(sw_state), 64'h61);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_sw", 64'(sw_state), 64'h0);
    chk("mid_rst_cursor", 64'(cursor), 64'h0);
    chk("mid_rst_valid", 64'(ev_valid), 64'h0);
    chk("mid_rst_index", 64'(ev_index), 64'h0);
    chk("mid_rst_state", 64'(ev_state), 64'h0);
    chk("mid_rst_overrun", 64'(ev_overrun), 64'h0);
    reset = 1'b0;
    key(1'b0, 1'b1, K_U);
    tick(20);
    chk("post_rst_sw", 64'(sw_state), 64'h0);
    chk("post_rst_valid", 64'(ev_valid), 64'h0);
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/panel_switch_ctrl.md
# panel_switch_ctrl

Parametrised keyboard-driven controller for front-panel toggle and momentary switches. It decodes PS/2 key events into a cursor position and per-switch 3-position states, and times momentary auto-return. It reports each state change through a one-entry valid/ready event port. It sits between hps_io's ps2_key and front_panel/front_panel_mapping, replacing their fixed 25-switch array.

## Interface
- SWITCH_COUNT, 25: number of panel switches; legal range 2..64.
- MOMENTARY_MASK, 64'h0: bit i=1 makes switch i momentary; bits at SWITCH_COUNT and above are ignored.
- HOLD_CYCLES, 24'd2_000_000: minimum number of cycles a momentary switch stays deflected.
- IDX_W, $clog2(SWITCH_COUNT): derived; not overridden.

Ports (clock and reset first):
- clk  in  1  system clock (CLK_VIDEO domain).
- reset  in  1  synchronous, active-high.
- ps2_key  in  11  hps_io format: [10] toggles once per event, [9] pressed, [8] extended, [7:0] scancode.
- sw_state  out  2*SWITCH_COUNT  switch i occupies [2i+1:2i]; 00 center, 01 up, 10 down; 11 is never driven.
- cursor  out  IDX_W  currently selected switch.
- ev_valid  out  1  a state-change event is pending.
- ev_index  out  IDX_W  switch index of the pending event.
- ev_state  out  2  new state of the pending event.
- ev_ready  in  1  consumer accepts the event.
- ev_overrun  out  1  sticky; an unconsumed event was overwritten.

## Operation
- Event detect: a key event occurs when ps2_key[10] differs from the registered copy kbit_q. kbit_q updates every cycle.
- Extended key decode:
  - E0 74 (right) press: cursor+1; SWITCH_COUNT-1 wraps to 0.
  - E0 6B (left) press: cursor-1; 0 wraps to SWITCH_COUNT-1.
  - E0 75 (up) press sets the target switch to 01; E0 72 (down) press sets it to 10.
- All other keys and all non-arrow releases are ignored.
- Toggle switch: up/down latches the new state. A press that matches the current state produces no change and no event.
- Momentary FSM, states IDLE / HELD / WAIT:
  - IDLE: an up/down press on a momentary cursor switch sets its state, loads hold_cnt=HOLD_CYCLES-1, records held_idx and held_key, and goes to HELD.
  - HELD: hold_cnt decrements toward 0 and saturates there. Release of held_key goes to WAIT.
  - WAIT: when hold_cnt==0, switch held_idx returns to 00 (this is an event) and the FSM goes to IDLE.
- While the FSM is not IDLE:
  - cursor moves are still honoured.
  - all up/down presses, on any switch, are ignored.
  - release of the non-held arrow is ignored.
- Event port:
  - Every sw_state change loads ev_index/ev_state and sets ev_valid.
  - ev_valid&ev_ready clears ev_valid.
  - A new change arriving while ev_valid&!ev_ready overwrites the event, keeps ev_valid=1, and sets ev_overrun.
  - A new change in the same cycle as an accept loads the new event, keeps ev_valid=1, and does not set ev_overrun.
- Reset (at any time, including mid-hold): all sw_state=00, cursor=0, ev_valid=0, ev_index=0, ev_state=00, ev_overrun=0, FSM=IDLE, hold_cnt=0, kbit_q<=ps2_key[10]. Reset therefore produces no spurious event.

## Timing
- Key-to-output latency: ps2_key changes before edge k; cursor/sw_state/ev_* update at edge k (registered outputs, 1 cycle).
- A momentary switch is deflected for at least HOLD_CYCLES cycles.
- If the key is released after the hold expires, the switch returns to center exactly 2 edges after the release is sampled: one edge enters WAIT, the next centers it.
- At most one key event is processed per cycle; hps_io spacing guarantees this.
- Overrun is decided on the same edge as the overwrite.

## Configuration
- PANEL_DIRECT_KEYS_EN defined: non-extended presses of keys '1'..'8' (scancodes 16,1E,26,25,2E,36,3D,3E) set cursor to 0..7.
  - Indices ≥SWITCH_COUNT are ignored.
  - These presses generate no event.
- PANEL_DIRECT_KEYS_EN undefined: those keys are ignored; the decoder has no logic for them.

## Structure
- Package panel_pkg:
  - sw_pos_t enum (SW_CENTER=2'b00, SW_UP=2'b01, SW_DOWN=2'b10).
  - mom_state_t enum (IDLE, HELD, WAIT).
  - Scancode localparams (SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, digit codes).
- Sub-module panel_key_decode: combinational decode of ps2_key plus kbit_q into one-hot cmd strobes (left, right, up_p, down_p, up_r, down_r, digit_v, digit_idx) and the kbit_q register.

## Test plan
- Reset, then 3× E0 74 press, then E0 6B press → cursor sequence 1,2,3,2; sw_state all zero; ev_valid stays 0.
- SWITCH_COUNT=4: cursor=3 then E0 74 press → cursor=0. Cursor=0 then E0 6B press → cursor=3.
- Toggle switch 2, E0 75 press → sw_state[5:4]=01, ev_valid=1, ev_index=2, ev_state=01. Repeat press → no change and no new event.
- HOLD_CYCLES=10, momentary switch 0: up press, release after 3 cycles → [1:0]=01 for exactly 10 cycles, then 00 with ev_state=00. Release after 20 cycles → centered 2 edges after the release.
- ev_ready=0, two toggle changes → ev_index/ev_state equal the second change, ev_overrun=1. Hold ev_ready=1 → ev_valid clears next edge; ev_overrun stays 1 until reset.
- Assert reset during HELD → all outputs return to reset values next edge. No centering event appears afterward.
